// File: rtl/ft_cmd_pkg.sv
// Shared definitions for the FT control-word register file.
package ft_cmd_pkg;

  // Opcode field values
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_ERR = 2'b11;

  // Field bit positions within a 32-bit command/response word
  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 30;
  localparam int unsigned ADDR_MSB = 29;
  localparam int unsigned ADDR_LSB = 24;
  localparam int unsigned DATA_MSB = 23;
  localparam int unsigned DATA_LSB = 0;

  // Special addresses above the R/W bank
  localparam logic [5:0] ADDR_STATUS  = 6'h3E;
  localparam logic [5:0] ADDR_VERSION = 6'h3F;

  // Error responses echo the address with a zero data field
  function automatic logic [31:0] err_rsp(input logic [5:0] addr);
    return {OP_ERR, addr, 24'h000000};
  endfunction

endpackage

// File: rtl/rsp_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word shown as zero when empty.
module rsp_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves the same cycle
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage; contents are don't-care while unoccupied so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ft_cmd_regfile.sv
// Decodes CPU-path control words, holds the control register bank and
// queues response words towards the CPU-command FIFO.
module ft_cmd_regfile
  import ft_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned REG_WIDTH  = 24,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter logic [23:0] VERSION    = 24'h000001
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         cmd_data_i,
  input  logic                          cmd_we_i,
  output logic                          cmd_full_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_we_o,
  input  logic                          rsp_full_i,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]           wr_strobe_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [5:0]  NUM_REGS_A = 6'(NUM_REGS);
  localparam logic [CNT_W-1:0] FULL_MARK = CNT_W'(RSP_DEPTH - 1);

  logic [1:0]            op;
  logic [5:0]            addr;
  logic [REG_WIDTH-1:0]  data;
  logic [IDX_W-1:0]      idx;
  logic                  in_bank;

  logic [REG_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_strobe_q;
  logic                  ovf_q, cmd_full_q;

  logic                  wr_en, ovf_clr, rsp_gen;
  logic [DATA_WIDTH-1:0] rsp_word;

  logic                  fifo_empty, fifo_full, rsp_push, rsp_pop;
  logic [CNT_W-1:0]      fifo_count, cnt_after;

  assign op      = cmd_data_i[OP_MSB:OP_LSB];
  assign addr    = cmd_data_i[ADDR_MSB:ADDR_LSB];
  assign data    = cmd_data_i[DATA_MSB:DATA_LSB];
  assign idx     = addr[IDX_W-1:0];
  assign in_bank = (addr < NUM_REGS_A);

  // Command decode: register write enable, status clear and response word
  always_comb begin
    wr_en    = 1'b0;
    ovf_clr  = 1'b0;
    rsp_gen  = 1'b0;
    rsp_word = '0;
    if (cmd_we_i) begin
      unique case (op)
        OP_NOP: ;
        OP_WR: begin
          if (in_bank) begin
            wr_en = 1'b1;
          end else if (addr == ADDR_STATUS) begin
            ovf_clr = 1'b1;
          end else begin
            rsp_gen  = 1'b1;
            rsp_word = err_rsp(addr);
          end
        end
        OP_RD: begin
          rsp_gen = 1'b1;
          if (in_bank) begin
            rsp_word = {OP_RD, addr, regs_q[idx]};
          end else if (addr == ADDR_VERSION) begin
            rsp_word = {OP_RD, ADDR_VERSION, VERSION};
          end else if (addr == ADDR_STATUS) begin
            rsp_word = {OP_RD, ADDR_STATUS, 21'b0, ovf_q, 2'b00};
          end else begin
            rsp_word = err_rsp(addr);
          end
        end
        OP_ERR: begin
          rsp_gen  = 1'b1;
          rsp_word = err_rsp(addr);
        end
        default: ;
      endcase
    end
  end

  // Responses drain whenever the downstream FIFO has room
  assign rsp_pop  = !fifo_empty && !rsp_full_i;
  assign rsp_we_o = rsp_pop;
  assign rsp_push = rsp_gen && (!fifo_full || rsp_pop);
  assign cnt_after = fifo_count + CNT_W'(rsp_push) - CNT_W'(rsp_pop);

  rsp_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_push),
    .pop_i   (rsp_pop),
    .wdata_i (rsp_word),
    .rdata_o (rsp_data_o),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Register bank and one-cycle write strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      wr_strobe_q <= '0;
    end else begin
      wr_strobe_q <= '0;
      if (wr_en) begin
        regs_q[idx]      <= data;
        wr_strobe_q[idx] <= 1'b1;
      end
    end
  end

  // Sticky overflow flag and registered backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      cmd_full_q <= 1'b0;
    end else begin
      cmd_full_q <= (cnt_after >= FULL_MARK);
      if (rsp_gen && fifo_full && !rsp_pop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_flat
    assign regs_o[k*REG_WIDTH +: REG_WIDTH] = regs_q[k];
  end

  assign wr_strobe_o = wr_strobe_q;
  assign cmd_full_o  = cmd_full_q;

endmodule

// File: doc/ft_cmd_regfile.md
Name: ft_cmd_regfile

Overview:
- Consumes the 32-bit control-word stream that the FT-to-AFE selector diverts to the CPU path (`cpu_data_o` / `cpu_we_o`).
- Decodes register WRITE/READ/NOP commands and holds a bank of control registers (mux, LED, loopback, AFE config).
- Pushes response words into the write side of the CPU-command FIFO, which the AFE-to-FT selector returns to the host.
- Sits between the `sel_f2a` CPU outputs and the `cpucmd_fifo` write port, in the FT clock domain.

Parameters:
- `DATA_WIDTH`, 32, command/response word width; the field layout below requires 32.
- `NUM_REGS`, 16, number of R/W control registers; max 62.
- `REG_WIDTH`, 24, width of each register (data field of a word).
- `RSP_DEPTH`, 4, internal response queue depth; must be a power of 2 and at least 2.
- `VERSION`, 24'h000001, value returned by a read of address 0x3F.

Ports:
- `clk` in 1: FT clock.
- `reset` in 1: synchronous, active-high.
- `cmd_data_i` in DATA_WIDTH: command word.
- `cmd_we_i` in 1: command word valid; one word per asserted cycle.
- `cmd_full_o` out 1: backpressure to the upstream selector.
- `rsp_data_o` out DATA_WIDTH: response word to `cpucmd_fifo` Data.
- `rsp_we_o` out 1: `cpucmd_fifo` WrEn.
- `rsp_full_i` in 1: `cpucmd_fifo` Full.
- `regs_o` out NUM_REGS*REG_WIDTH: flattened register bank; reg k occupies bits [k*REG_WIDTH +: REG_WIDTH].
- `wr_strobe_o` out NUM_REGS: one-cycle pulse per register written.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: all regs 0, `wr_strobe_o`=0, `rsp_we_o`=0, `rsp_data_o`=0, queue empty, `cmd_full_o`=0, overflow flag=0.
- Command word fields:
  - [31:30] opcode: 00 NOP, 01 WRITE, 10 READ, 11 reserved.
  - [29:24] addr.
  - [23:0] data.
- WRITE, addr < NUM_REGS, accepted at edge N:
  - reg[addr] updated, visible on `regs_o` from cycle N+1.
  - `wr_strobe_o[addr]`=1 for cycle N+1 only.
  - No response word.
- WRITE to addr 0x3E clears the overflow flag.
- WRITE to any other address ≥ NUM_REGS: ignored, and an error response is queued.
- READ: a response is queued at edge N, as follows.
  - addr < NUM_REGS → {2'b10, addr, reg[addr]}. If a WRITE to the same addr was accepted at edge N-1, the new value is returned.
  - addr 0x3F → {2'b10, 6'h3F, VERSION}.
  - addr 0x3E → {2'b10, 6'h3E, 21'b0, overflow, 2'b0}.
  - any other addr → error response {2'b11, addr, 24'h0}.
- Reserved opcode 11: error response {2'b11, addr, 24'h0}.
- NOP: no action, no response.
- Response queue: a FIFO of RSP_DEPTH words with a count register.
  - `rsp_we_o` = (count≠0) && !`rsp_full_i`, combinational from registered state. `rsp_data_o` shows the head word.
  - Pop on every cycle `rsp_we_o`=1.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Read-to-`rsp_we_o` latency is 1 cycle minimum: READ accepted at edge N gives `rsp_we_o` in cycle N+1 if the queue was empty and `rsp_full_i`=0.
- Backpressure:
  - `cmd_full_o` is registered, =1 when count ≥ RSP_DEPTH-1 after the current edge's update.
  - When `rsp_full_i`=1, the queue holds its contents; nothing is dropped from the queue.
- Overflow: a response-generating command arriving while count==RSP_DEPTH with no pop that cycle is handled as follows.
  - The response is discarded and the overflow flag is set (sticky).
  - A WRITE side effect still takes place.
- `cmd_we_i` is ignored during reset. Reset mid-operation flushes the queue and clears all regs that same edge.

Decomposition:
- Shared package `ft_cmd_pkg`: opcode constants (`OP_NOP`, `OP_WR`, `OP_RD`, `OP_ERR`), field bit positions, and special addresses `ADDR_STATUS`=6'h3E, `ADDR_VERSION`=6'h3F.
- One sub-module, `rsp_sync_fifo`: parameterised width/depth synchronous FIFO with count, push, pop, empty and full.
- Decode logic and the register bank stay in the top of the block.

Test Plan:
- WRITE {01, 6'h02, 24'hABCDEF} then READ addr 2 on the next cycle → `regs_o` reg2=ABCDEF in cycle N+1, `wr_strobe_o`=16'h0004 for exactly one cycle, response 32'h82ABCDEF with `rsp_we_o` one cycle after the READ.
- READ 0x3F with `rsp_full_i`=0 → `rsp_data_o`=32'hBF000001, `rsp_we_o` for exactly one cycle.
- Hold `rsp_full_i`=1 and issue 5 back-to-back READs of addr 0:
  - `cmd_full_o` rises after the 3rd accept.
  - The 5th response is dropped and READ 0x3E later shows overflow=1.
  - Releasing `rsp_full_i` drains exactly 4 words in order.
- READ addr 0x20, and separately a reserved-opcode word 32'hC5000000 → responses 32'hE0000000 and 32'hC5000000; no register changes.
- Push and pop in the same cycle with queue count=2 → count stays 2 and the words leave in order.
- Assert `reset` with 2 queued responses and non-zero regs → next cycle `rsp_we_o`=0, all regs 0, `cmd_full_o`=0, overflow cleared.
